// File: rtl/bnn_layer_seq.sv
// BNN inference sequencer: image load, then each layer engine in turn.
// Carries a per-stage watchdog, an abort path and an optional continuous mode.
module bnn_layer_seq #(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = 0,
  parameter int CONTINUOUS = 0,
  localparam int LIDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  abort,
  input  logic                  load_done,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [2:0]            state,
  output logic [LIDX_W-1:0]     layer_idx,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic                  busy,
  output logic                  infer_done,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LIDX_W-1:0] IDX_LAST =
    LIDX_W'(NUM_LAYERS - 1);

  state_t              st_q, st_d;
  logic [LIDX_W-1:0]   idx_q, idx_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                start_q, start_d;
  logic [NUM_LAYERS-1:0] sel;
  logic                cur_done;
  logic                last;
  logic                wd_exp;

  // Only the active layer's done bit can advance the sequence.
  assign sel      = NUM_LAYERS'(1) << idx_q;
  assign cur_done = |(layer_done & sel);
  assign last     = (idx_q == IDX_LAST);
  assign wd_exp   = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      idx_q   <= '0;
      wd_q    <= '0;
      start_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE: if (mode) st_d = S_LOAD;
      S_LOAD: begin
        if (abort)          st_d = S_IDLE;
        else if (load_done) st_d = S_RUN;
        else if (wd_exp)    st_d = S_ERR;
      end
      S_RUN: begin
        if (abort)         st_d = S_IDLE;
        else if (cur_done) st_d = last ? S_DONE : S_RUN;
        else if (wd_exp)   st_d = S_ERR;
      end
      S_DONE: begin
        if (!abort && (CONTINUOUS != 0) && mode) st_d = S_LOAD;
        else                                     st_d = S_IDLE;
      end
      S_ERR: if (!mode || abort) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // Layer index and watchdog restart on every stage entry.
  always_comb begin
    idx_d   = '0;
    wd_d    = '0;
    start_d = 1'b0;
    if (st_d == S_RUN) begin
      if (st_q != S_RUN) begin
        start_d = 1'b1;
      end else if (cur_done) begin
        idx_d   = idx_q + LIDX_W'(1);
        start_d = 1'b1;
      end else begin
        idx_d = idx_q;
        wd_d  = wd_q + WD_W'(1);
      end
    end else if (st_q == S_LOAD && st_d == S_LOAD) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_comb begin
    state       = st_q;
    layer_idx   = '0;
    layer_en    = '0;
    layer_start = '0;
    busy        = 1'b0;
    infer_done  = 1'b0;
    timeout_err = 1'b0;
    unique case (st_q)
      S_LOAD: busy = 1'b1;
      S_RUN: begin
        busy        = 1'b1;
        layer_idx   = idx_q;
        layer_en    = sel;
        layer_start = start_q ? sel : '0;
      end
      S_DONE: begin
        busy       = 1'b1;
        infer_done = 1'b1;
      end
      S_ERR:   timeout_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Bench for bnn_layer_seq: two configurations on shared stimulus,
// checked cycle by cycle against a stage/age reference model.
module tb_bnn_layer_seq;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mode = 1'b0;
  logic abort = 1'b0;
  logic load_done = 1'b0;
  logic [N-1:0] layer_done = '0;

  logic [2:0] a_state, b_state;
  logic [1:0] a_idx, b_idx;
  logic [N-1:0] a_en, b_en, a_start, b_start;
  logic a_busy, b_busy, a_done, b_done, a_err, b_err;
  logic [13:0] a_v, b_v;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    int st;
    int layer;
    int age;
    bit start;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  bnn_layer_seq #(.NUM_LAYERS(N), .TIMEOUT(16), .CONTINUOUS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .abort(abort),
    .load_done(load_done), .layer_done(layer_done),
    .state(a_state), .layer_idx(a_idx), .layer_en(a_en),
    .layer_start(a_start), .busy(a_busy), .infer_done(a_done),
    .timeout_err(a_err)
  );

  bnn_layer_seq #(.NUM_LAYERS(N), .TIMEOUT(0), .CONTINUOUS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .abort(abort),
    .load_done(load_done), .layer_done(layer_done),
    .state(b_state), .layer_idx(b_idx), .layer_en(b_en),
    .layer_start(b_start), .busy(b_busy), .infer_done(b_done),
    .timeout_err(b_err)
  );

  assign a_v = {a_state, a_idx, a_en, a_start, a_busy, a_done, a_err};
  assign b_v = {b_state, b_idx, b_en, b_start, b_busy, b_done, b_err};

  // Stage model: age counts completed cycles in the current stage.
  function automatic mdl_t step(mdl_t m, int tmo, bit cont);
    mdl_t n = m;
    bit expire = (tmo != 0) && (m.age + 1 == tmo);
    n.start = 1'b0;
    case (m.st)
      0: if (mode) begin n.st = 1; n.age = 0; end
      1: begin
        if (abort) n.st = 0;
        else if (load_done) begin
          n.st = 2; n.layer = 0; n.age = 0; n.start = 1'b1;
        end else if (expire) n.st = 4;
        else n.age = m.age + 1;
      end
      2: begin
        if (abort) n.st = 0;
        else if (layer_done[m.layer]) begin
          if (m.layer == N - 1) n.st = 3;
          else begin
            n.layer = m.layer + 1; n.age = 0; n.start = 1'b1;
          end
        end else if (expire) n.st = 4;
        else n.age = m.age + 1;
      end
      3: begin
        if (!abort && cont && mode) begin n.st = 1; n.age = 0; end
        else n.st = 0;
      end
      4: if (!mode || abort) n.st = 0;
      default: n.st = 0;
    endcase
    if (n.st != 2) n.layer = 0;
    return n;
  endfunction

  function automatic logic [13:0] mexp(mdl_t m);
    logic [2:0] oh = (m.st == 2) ? 3'(1 << m.layer) : 3'b000;
    logic [1:0] ix = (m.st == 2) ? 2'(m.layer) : 2'd0;
    return {3'(m.st), ix, oh, (m.start ? oh : 3'b000),
            (m.st inside {1, 2, 3}), (m.st == 3), (m.st == 4)};
  endfunction

  task automatic chk(input string tag, input logic [13:0] obs,
                     input logic [13:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ma = step(ma, 16, 1'b0);
    mb = step(mb, 0, 1'b1);
    #1;
    chk("a_cycle", a_v, mexp(ma));
    chk("b_cycle", b_v, mexp(mb));
  endtask

  task automatic mreset();
    ma = '{0, 0, 0, 1'b0};
    mb = '{0, 0, 0, 1'b0};
  endtask

  initial begin
    mreset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_a", a_v, 14'd0);
    chk("reset_b", b_v, 14'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal pass with spaced done pulses
    mode = 1'b1;
    tick();
    mode = 1'b0;
    chk("t1_load", {11'd0, b_state}, 14'd1);
    chk("t1_busy", {13'd0, b_busy}, 14'd1);
    repeat (4) tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("t1_run0", {11'd0, b_state}, 14'd2);
    chk("t1_start0", {11'd0, b_start}, 14'd1);
    for (int k = 0; k < N; k++) begin
      repeat (3) tick();
      layer_done = 3'(1 << k);
      tick();
      layer_done = '0;
      if (k < N - 1) begin
        chk("t1_idx", {12'd0, b_idx}, 14'(k + 1));
        chk("t1_start", {11'd0, b_start}, 14'(1 << (k + 1)));
      end
    end
    chk("t1_done", {11'd0, b_state}, 14'd3);
    chk("t1_infer", {13'd0, b_done}, 14'd1);
    tick();
    chk("t1_idle", {11'd0, b_state}, 14'd0);
    chk("t1_infer_off", {13'd0, b_done}, 14'd0);

    // Stray done bits on inactive layers
    mode = 1'b1;
    tick();
    mode = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    layer_done = 3'b110;
    tick();
    chk("t2_stray", {12'd0, b_idx}, 14'd0);
    layer_done = 3'b001;
    tick();
    chk("t2_adv", {12'd0, b_idx}, 14'd1);
    layer_done = 3'b010;
    tick();
    layer_done = 3'b100;
    tick();
    layer_done = '0;
    tick();

    // Watchdog expiry in LOAD
    mode = 1'b1;
    tick();
    repeat (15) tick();
    chk("t3_load16", {11'd0, a_state}, 14'd1);
    tick();
    chk("t3_err", {11'd0, a_state}, 14'd4);
    chk("t3_err_flag", {13'd0, a_err}, 14'd1);
    tick();
    chk("t3_err_hold", {11'd0, a_state}, 14'd4);
    mode = 1'b0;
    tick();
    chk("t3_idle", {11'd0, a_state}, 14'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Done arriving in the final allowed cycle
    mode = 1'b1;
    tick();
    repeat (15) tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    mode = 1'b0;
    chk("t3_late_ok", {11'd0, a_state}, 14'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Abort beats a simultaneous layer done
    mode = 1'b1;
    tick();
    mode = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    layer_done = 3'b001;
    tick();
    chk("t4_idx1", {12'd0, a_idx}, 14'd1);
    abort = 1'b1;
    layer_done = 3'b010;
    tick();
    abort = 1'b0;
    layer_done = '0;
    chk("t4_abort_a", a_v, 14'd0);
    chk("t4_abort_b", b_v, 14'd0);
    tick();

    // Continuous vs single-shot with mode held
    mode = 1'b1;
    tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      layer_done = 3'(1 << k);
      tick();
    end
    layer_done = '0;
    chk("t5_done_b", {13'd0, b_done}, 14'd1);
    chk("t5_done_a", {13'd0, a_done}, 14'd1);
    tick();
    chk("t5_cont", {11'd0, b_state}, 14'd1);
    chk("t5_single", {11'd0, a_state}, 14'd0);
    mode = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset in RUN
    mode = 1'b1;
    tick();
    mode = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_async_a", a_v, 14'd0);
    chk("t6_async_b", b_v, 14'd0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1'b1;
    tick();
    mode = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      layer_done = 3'(1 << k);
      tick();
    end
    layer_done = '0;
    chk("t6_restart", {13'd0, a_done}, 14'd1);
    tick();

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      mode = ($urandom_range(0, 7) < 6);
      abort = ($urandom_range(0, 63) == 0);
      load_done =
        ($urandom_range(0, ((i / 500) % 2 == 1) ? 24 : 3) == 0);
      layer_done =
        ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_layer_seq.md
# bnn_layer_seq

Parametrised top-level sequencer for the BNN inference datapath. It walks the image-load phase and then NUM_LAYERS network layers in order, and drives per-layer enable and start strobes. A per-stage watchdog, an abort path and an optional continuous-inference mode are included. It sits between the top-level mode/reset pins and the load unit and layer engines, and reports its state to the top-level output mux.

## Interface

Parameters:
- NUM_LAYERS, 3: number of layer engines sequenced; legal range 1..8.
- TIMEOUT, 0: maximum cycles any one stage (LOAD or a layer) may occupy; 0 disables the watchdog.
- CONTINUOUS, 0: when 1, DONE returns directly to LOAD if mode is still high.
- Derived LIDX_W = max(1, $clog2(NUM_LAYERS)); WD_W = max(1, $clog2(TIMEOUT+1)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  1  inference request (level).
- abort  in  1  synchronous abort request.
- load_done  in  1  image load complete.
- layer_done  in  NUM_LAYERS  per-layer completion; only bit [layer_idx] is honoured.
- state  out  3  IDLE=0, LOAD=1, RUN=2, DONE=3, ERR=4.
- layer_idx  out  LIDX_W  active layer; 0 outside RUN.
- layer_en  out  NUM_LAYERS  one-hot of layer_idx while in RUN, else 0.
- layer_start  out  NUM_LAYERS  one-cycle pulse on the first RUN cycle of each layer.
- busy  out  1  high in LOAD, RUN and DONE.
- infer_done  out  1  high for exactly the one DONE cycle.
- timeout_err  out  1  high while in ERR.

## Operation

- All outputs are registered or decoded from registered state. On reset every output is 0, state=IDLE and the watchdog is 0.
- State transitions:
  - IDLE: mode=1 goes to LOAD; otherwise the block holds.
  - LOAD: load_done goes to RUN with layer_idx=0.
  - RUN: layer_done[layer_idx]=1 with layer_idx<NUM_LAYERS-1 increments layer_idx and stays in RUN. With layer_idx=NUM_LAYERS-1 it goes to DONE.
  - DONE: lasts one cycle, then goes to LOAD if CONTINUOUS=1 and mode=1, otherwise to IDLE.
  - ERR: held until mode=0, then goes to IDLE. abort also exits ERR to IDLE.
  - Unreachable encodings go to IDLE on the next clock.
- Priority in LOAD, RUN and DONE is abort > done > timeout. abort=1 forces IDLE next cycle and clears layer_idx and the watchdog. abort in IDLE is ignored.
- Watchdog:
  - It clears on entry to LOAD and on every layer entry, including the increment within RUN.
  - It increments each LOAD/RUN cycle in which the relevant done is low.
  - If TIMEOUT≠0, the counter equals TIMEOUT-1 and the done is low, the next state is ERR.
  - A done that arrives in the TIMEOUT-th cycle of the stage is accepted.
- Bits of layer_done other than [layer_idx] are ignored in every state. load_done outside LOAD is ignored.
- The minimum residency per layer is 1 cycle. A done asserted in the same cycle as layer_start is accepted.
- Asserting rst_n low mid-operation asynchronously returns the block to IDLE and clears all outputs in the same cycle.

## Timing

- The cycle after mode is sampled high in IDLE, state=1 and busy=1.
- After load_done is sampled, the next cycle has state=2, layer_idx=0, layer_en[0]=1 and layer_start[0]=1.
- Each sampled layer_done[k], with k<NUM_LAYERS-1, gives layer_idx=k+1 and layer_start[k+1]=1 in the next cycle.
- The minimum full pass is 1 (LOAD) + NUM_LAYERS (RUN) + 1 (DONE) cycles after leaving IDLE.
- layer_start is never high for more than one consecutive cycle for the same layer.

## Test plan

- NUM_LAYERS=3, TIMEOUT=0: pulse mode, then load_done after 5 cycles and each layer_done after 4 cycles. Required: state sequence 0,1,2,3,0, layer_idx 0,1,2, three single-cycle layer_start pulses, and infer_done high exactly one cycle.
- Stray done: assert layer_done=3'b110 while layer_idx=0. Required: no advance. Then assert 3'b001 and check that layer_idx=1 the next cycle.
- TIMEOUT=16: never assert load_done. Required: state=4 and timeout_err=1 after exactly 16 LOAD cycles. With a second run where load_done is asserted in cycle 16, the block must reach RUN and not ERR. Deassert mode and check for IDLE.
- abort in RUN at layer_idx=1, asserted together with layer_done[1]. Required: next state IDLE, layer_en=0 and no infer_done.
- CONTINUOUS=1 with mode held high: after DONE, state=1 on the next cycle. With CONTINUOUS=0, state=0 instead.
- Drop rst_n asynchronously between clock edges while in RUN. Required: all outputs 0 before the next edge, and a normal restart after release.
